dm_access_ctrl: RTL
===================

Name: dm_access_ctrl

Overview:
Sequences all data-memory accesses for the DM stage of the SimpleRISC pipeline. It runs a req/ack handshake to a variable-latency data memory and generates DMdone, which the stall logic consumes to hold the pipeline on loads. Stores are posted through a single-entry write buffer, so the pipeline does not stall on a store unless the buffer is occupied.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT_CYCLES, 255, max wait cycles per access (used only with DM_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
is_Ld  in  1  load instruction present in DM stage
is_St  in  1  store instruction present in DM stage
stop  in  1  global pipeline freeze; DM-stage instruction does not advance
alu_addr  in  AW  effective address from ALU stage
st_data  in  DW  store data
DMdone  out  1  load complete, ld_data valid
ld_data  out  DW  load result
st_full  out  1  store cannot be accepted; stall logic must freeze pipeline
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
mem_ack  in  1  access complete; sampled only while mem_req=1
dm_err  out  1  sticky timeout flag (DM_TIMEOUT_EN only)

Behaviour:
- Reset (async, rst_n=0): state IDLE, wb_valid=0. All outputs 0: DMdone, ld_data, st_full, mem_req, mem_we, mem_addr, mem_wdata, dm_err. Reset mid-access aborts it: mem_req drops immediately and any buffered store is discarded.
- mem_* outputs, DMdone and ld_data are registered. st_full is combinational: st_full = is_St & wb_valid.
- States: IDLE, ST_WAIT, LD_WAIT, LD_DONE.
- IDLE transitions:
  - is_Ld & ~wb_valid: latch alu_addr, go to LD_WAIT with mem_req=1, mem_we=0.
  - is_St & ~stop & ~wb_valid: capture alu_addr/st_data into the buffer, wb_valid=1, go to ST_WAIT with mem_req=1, mem_we=1.
  - A store is captured exactly once. While stop=1 it is not captured.
- ST_WAIT: hold mem_req/mem_we/mem_addr/mem_wdata stable until mem_ack.
  - On ack, wb_valid=0.
  - If is_Ld is high in the ack cycle, go directly to LD_WAIT with a read request the next cycle (mem_req stays 1, mem_we becomes 0).
  - Otherwise go to IDLE and deassert mem_req.
- LD_WAIT: hold the request until mem_ack. On ack, ld_data<=mem_rdata, mem_req<=0, DMdone<=1, go to LD_DONE.
- LD_DONE: DMdone=1, ld_data held.
  - stop=1: remain in LD_DONE, since the load has not advanced.
  - stop=0: go to IDLE with DMdone<=0.
  - A back-to-back load then seen in IDLE is a new instruction.
- Load latency:
  - is_Ld first seen in cycle 0 with buffer empty: mem_req in cycle 1, earliest ack in cycle 1, DMdone in cycle 2.
  - Each extra memory wait cycle adds 1.
- Ordering: a load never issues while wb_valid=1. A store pending ahead of a load always completes first.
- Simultaneous events:
  - is_Ld and is_St both high: treat as a load; the store is ignored (illegal encoding).
  - mem_ack while mem_req=0: ignored.
- Width rules: no arithmetic on data. Address and data pass through unmodified.

Optional Feature:
Macro: DM_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to LD_WAIT/ST_WAIT and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops and dm_err sets (sticky until reset).
  - A timed-out load completes with ld_data=0 and DMdone=1 via LD_DONE. A timed-out store is discarded (wb_valid=0) and the FSM returns to IDLE.
- Undefined: no counter, wait is unbounded, dm_err tied 0.

Test Plan:
- Load, ack 3 cycles after req, mem_rdata=32'hDEADBEEF: mem_req high cycles 1-4, mem_we=0; DMdone=1 in cycle 5 with ld_data=32'hDEADBEEF; IDLE in cycle 6.
- Store addr=0x40, data=0x1234, stop=0, ack after 2 cycles: exactly one write request with mem_we=1, addr 0x40, data 0x1234; st_full=0 during capture; DMdone never asserted.
- Store pending (no ack yet), second store arrives: st_full=1 until the ack cycle; the second store is captured in the cycle after ack; two writes in order.
- Store pending then load 0x80: no read issues before write ack; read starts the cycle after ack; DMdone only after read ack.
- Load completes while stop=1 for 4 cycles: DMdone and ld_data held all 4 cycles, no new mem_req; IDLE one cycle after stop falls. Second scenario: rst_n pulsed low mid-LD_WAIT gives mem_req=0 immediately and all outputs 0.
- DM_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never asserted on a load: mem_req drops after 8 wait cycles; dm_err=1 and stays; DMdone=1 with ld_data=0.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: data-memory access sequencer for the DM stage.
//   Runs a req/ack handshake to a variable-latency data memory. Loads stall
//   the pipeline until DMdone; stores are posted through a single-entry write
//   buffer and only stall (st_full) when a second store meets a pending one.
//   A pending store always completes before a load is issued.
//
// Optional feature: DM_TIMEOUT_EN bounds every memory wait to TIMEOUT_CYCLES
//   cycles; a timed-out access sets the sticky dm_err flag. A timed-out load
//   returns ld_data=0 with DMdone=1, and a timed-out store is dropped.
//   Without the macro the wait is unbounded and dm_err is constant 0.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   is_Ld, is_St, stop    DM-stage instruction type and global freeze
//   alu_addr, st_data     effective address / store data
//   DMdone, ld_data       load complete strobe (held while stop=1) and result
//   st_full               combinational: store present while buffer occupied
//   mem_req, mem_we,      registered memory request
//   mem_addr, mem_wdata
//   mem_rdata, mem_ack    memory response; ack ignored while mem_req=0
//   dm_err                sticky timeout flag
module dm_access_ctrl #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          is_Ld,
  input  logic          is_St,
  input  logic          stop,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] st_data,
  output logic          DMdone,
  output logic [DW-1:0] ld_data,
  output logic          st_full,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          dm_err
);

  typedef enum logic [1:0] {IDLE, ST_WAIT, LD_WAIT, LD_DONE} state_t;

  // Registered memory request. While a store is buffered, addr/wdata are the
  // write buffer contents; wb_valid marks them as an outstanding store.
  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  state_t        state, state_n;
  mreq_t         mreq, mreq_n;
  logic          wb_valid, wb_valid_n;
  logic          done_n;
  logic [DW-1:0] ld_data_n;

`ifdef DM_TIMEOUT_EN
  localparam int CLW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CLW > 8) ? CLW : 8;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          err_q, err_n;
  logic          timeout;

  // Counter holds the number of completed un-acked wait cycles; the access
  // is abandoned at the edge that would make it TIMEOUT_CYCLES.
  assign cnt_inc = cnt + 1'b1;
  assign timeout = (cnt_inc == TO_MAX);
  assign dm_err  = err_q;
`else
  // Constant 0 for any legal TIMEOUT_CYCLES.
  assign dm_err  = (TIMEOUT_CYCLES < 0);
`endif

  assign st_full   = is_St & wb_valid;
  assign mem_req   = mreq.req;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;

  always_comb begin
    state_n    = state;
    mreq_n     = mreq;
    wb_valid_n = wb_valid;
    done_n     = DMdone;
    ld_data_n  = ld_data;
`ifdef DM_TIMEOUT_EN
    cnt_n      = cnt;
    err_n      = err_q;
`endif
    case (state)
      IDLE: begin
        // Load wins over a simultaneous store (illegal encoding).
        if (is_Ld && !wb_valid) begin
          state_n     = LD_WAIT;
          mreq_n.req  = 1'b1;
          mreq_n.we   = 1'b0;
          mreq_n.addr = alu_addr;
`ifdef DM_TIMEOUT_EN
          cnt_n       = '0;
`endif
        end else if (is_St && !stop && !wb_valid) begin
          state_n      = ST_WAIT;
          wb_valid_n   = 1'b1;
          mreq_n.req   = 1'b1;
          mreq_n.we    = 1'b1;
          mreq_n.addr  = alu_addr;
          mreq_n.wdata = st_data;
`ifdef DM_TIMEOUT_EN
          cnt_n        = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          wb_valid_n = 1'b0;
          if (is_Ld) begin
            // Chain straight into the read; mem_req never drops.
            state_n     = LD_WAIT;
            mreq_n.we   = 1'b0;
            mreq_n.addr = alu_addr;
`ifdef DM_TIMEOUT_EN
            cnt_n       = '0;
`endif
          end else begin
            state_n    = IDLE;
            mreq_n.req = 1'b0;
          end
        end
`ifdef DM_TIMEOUT_EN
        else if (timeout) begin
          state_n    = IDLE;
          wb_valid_n = 1'b0;
          mreq_n.req = 1'b0;
          err_n      = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
`endif
      end
      LD_WAIT: begin
        if (mem_ack) begin
          state_n    = LD_DONE;
          mreq_n.req = 1'b0;
          done_n     = 1'b1;
          ld_data_n  = mem_rdata;
        end
`ifdef DM_TIMEOUT_EN
        else if (timeout) begin
          state_n    = LD_DONE;
          mreq_n.req = 1'b0;
          done_n     = 1'b1;
          ld_data_n  = '0;
          err_n      = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
`endif
      end
      LD_DONE: begin
        // Hold the result until the load actually leaves the stage.
        if (!stop) begin
          state_n = IDLE;
          done_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mreq     <= '0;
      wb_valid <= 1'b0;
      DMdone   <= 1'b0;
      ld_data  <= '0;
    end else begin
      state    <= state_n;
      mreq     <= mreq_n;
      wb_valid <= wb_valid_n;
      DMdone   <= done_n;
      ld_data  <= ld_data_n;
    end
  end

`ifdef DM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end
`endif

endmodule
